booth_sequencer: RTL and testbench
==================================

Name: booth_sequencer

Overview:
- Sequential radix-2 Booth controller and datapath for the 8x8 signed multiplier; the stage directly upstream of the 8-bit add/sub stage.
- Holds accumulator A, multiplier shift register Q, bit q_1, multiplicand M and an iteration counter.
- Each iteration drives one instance of the existing 8-bit add/sub stage with i0=A, i1=M and cin=subtract, then arithmetic-right-shifts the result.
- Delivers a 16-bit signed product with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand width. Must equal the add/sub stage width; only 8 is supported.
- CNT_W, 4, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- multiplicand  input  8  signed M; sampled on the accepting edge
- multiplier  input  8  signed Q; sampled on the accepting edge
- busy  output  1  high while state is CALC
- done  output  1  one-cycle pulse; product valid
- product  output  16  signed {A,Q} result; held until the next result

Behaviour:
- Reset (asynchronous, active-high, immediate): state=IDLE; A, Q, q_1, M, counter, busy, done and product all cleared to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 -> capture M, Q, q_1=0, A=0, counter=WIDTH; go to CALC.
  - Otherwise remain in IDLE.
- CALC, one iteration per clock, selected by {Q[0],q_1}:
  - 01 -> add: cin=0, S = A+M.
  - 10 -> subtract: cin=1, S = A-M.
  - 00 or 11 -> S = A; add/sub stage output is ignored.
- 9-bit sign recovery, so M=-128 works with the 8-bit stage:
  - b = M XOR {8{cin}}.
  - ovf = (A[7]==b[7]) && (S[7]!=A[7]), only on add/sub steps; 0 otherwise.
  - True sign t = S[7] XOR ovf.
- Shift (all registers update on the same edge): A <= {t, S[7:1]}; Q <= {S[0], Q[7:1]}; q_1 <= Q[0]; counter <= counter-1.
- Iteration end:
  - If counter was 1: product <= shifted {A,Q}, done=1, state=DONE.
  - Otherwise stay in CALC.
- Latency: start accepted at edge E0; iterations on E1..E8; done high in the cycle after E8. Total 8 cycles of busy, then 1 cycle of done.
- DONE (lasts exactly one cycle): done=1, busy=0.
  - start=1 is accepted exactly as in IDLE (back-to-back operation) and the next state is CALC.
  - Otherwise the next state is IDLE.
- start while in CALC is ignored. Input changes during CALC have no effect.
- product is not cleared when a new operation starts; it changes only on the final-iteration edge or on reset.
- Reset during CALC aborts the operation: done is never pulsed for it and product reads 0.
- Results are exact for all 65536 operand pairs, including -128*-128 = 16384.

Optional Feature:
- Macro: BOOTH_EARLY_DONE_EN.
- Enabled: in CALC, if Q[counter-1:0] and q_1 are all 0 or all 1, every remaining step is a pure shift. That cycle the block:
  - performs this cycle's step;
  - applies an arithmetic right shift of {A,Q} by the remaining counter-1 steps;
  - writes product, pulses done and goes to DONE.
  - The product is identical to the full-length result. busy lasts 1-8 cycles.
- Disabled: fixed 8 CALC cycles; the detection logic is absent.

Test Plan:
- 3 x 5 (0x03, 0x05) -> product=0x000F; busy high for 8 cycles; done high exactly one cycle, the cycle after the 8th iteration edge.
- -128 x -128 (0x80, 0x80) -> 0x4000. Also 127 x -128 (0x7F, 0x80) -> 0xC080, and -128 x 127 -> 0xC080.
- -7 x 6 (0xF9, 0x06) -> 0xFFD6. Then with start held high in the DONE cycle and new operands 0x02 x 0xFF -> next product 0xFFFE, with no IDLE cycle in between.
- start re-pulsed with different operands during CALC -> ignored; product from the original operands.
- rst asserted asynchronously mid-CALC (between clock edges) -> busy, done and product go to 0 immediately. A following start with 4 x 4 -> 0x0010.
- With BOOTH_EARLY_DONE_EN:
  - 0x25 x 0x00 -> product 0x0000, done after 1 CALC cycle.
  - 0x05 x 0xFF -> 0xFFFB, done after 2 CALC cycles (the step-1 subtract is followed by an all-ones window).
  - Without the macro, both cases take 8 cycles and give the same products.

Source files
------------

// File: rtl/booth_sequencer.sv
// Sequential radix-2 Booth 8x8 signed multiplier controller and datapath; BOOTH_EARLY_DONE_EN enables early finish.
// Latency: start accepted at edge E0, iterations on E1..E8 (fewer with early finish), done pulses the following cycle.
// Backpressure: none; start is honoured only in IDLE or DONE, and is ignored while busy.
module booth_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic               q_1;
    logic [CNT_W-1:0]   counter;

    logic               add_step;
    logic               sub_step;
    logic               op_step;
    logic               cin;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   s_stage;
    logic [WIDTH-1:0]   s;
    logic               ovf;
    logic               t;
    logic [WIDTH-1:0]   next_a;
    logic [WIDTH-1:0]   next_q;
    logic               last_step;
    logic [2*WIDTH-1:0] final_prod;

    assign add_step = ~q[0] & q_1;
    assign sub_step = q[0] & ~q_1;
    assign op_step  = add_step | sub_step;
    assign cin      = sub_step;

    booth_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i0  (a),
        .i1  (m),
        .cin (cin),
        .s   (s_stage)
    );

    // The 8-bit stage drops the 9th bit; recover the true sign so M=-128 still works.
    assign b      = m ^ {WIDTH{cin}};
    assign ovf    = op_step && (a[WIDTH-1] == b[WIDTH-1]) && (s_stage[WIDTH-1] != a[WIDTH-1]);
    assign s      = op_step ? s_stage : a;
    assign t      = s[WIDTH-1] ^ ovf;
    assign next_a = {t, s[WIDTH-1:1]};
    assign next_q = {s[0], q[WIDTH-1:1]};

`ifdef BOOTH_EARLY_DONE_EN
    logic [WIDTH-1:0]           window_mask;
    logic                       window_zero;
    logic                       window_ones;
    logic signed [2*WIDTH-1:0]  shifted;

    // Remaining multiplier bits plus q_1 uniform: every later step is a pure shift.
    assign window_mask = ~({WIDTH{1'b1}} << counter);
    assign window_zero = ((q & window_mask) == '0) && !q_1;
    assign window_ones = ((q & window_mask) == window_mask) && q_1;
    assign shifted     = $signed({next_a, next_q}) >>> (counter - CNT_W'(1));
    assign last_step   = (counter == CNT_W'(1)) || window_zero || window_ones;
    assign final_prod  = shifted;
`else
    assign last_step   = (counter == CNT_W'(1));
    assign final_prod  = {next_a, next_q};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m       <= multiplicand;
                        q       <= multiplier;
                        q_1     <= 1'b0;
                        a       <= '0;
                        counter <= CNT_W'(WIDTH);
                        busy    <= 1'b1;
                        state   <= CALC;
                    end else begin
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                CALC: begin
                    a       <= next_a;
                    q       <= next_q;
                    q_1     <= q[0];
                    counter <= counter - CNT_W'(1);
                    if (last_step) begin
                        product <= final_prod;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// 8-bit add/sub stage: s = i0 + i1 when cin=0, i0 - i1 when cin=1.
// Latency: combinational.
// Backpressure: none.
module booth_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             cin,
    output logic [WIDTH-1:0] s
);

    assign s = i0 + (i1 ^ {WIDTH{cin}}) + WIDTH'(cin);

endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer: cycle-level behavioural model plus directed literal checks and random operands.
module tb_booth_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_chk = 0;
    int n_fail = 0;

    booth_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of CALC cycles for a given multiplier.
    function automatic int calc_cycles(input logic [7:0] mp);
`ifdef BOOTH_EARLY_DONE_EN
        logic [8:0] ext;
        logic       uniform;
        ext = {mp, 1'b0};
        for (int k = 1; k <= 8; k++) begin
            uniform = 1'b1;
            for (int j = k - 1; j <= 8; j++)
                if (ext[j] != ext[8]) uniform = 1'b0;
            if (uniform) return k;
        end
        return 8;
`else
        return 8;
`endif
    endfunction

    function automatic logic [15:0] signed_mul(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return p[15:0];
    endfunction

    // Behavioural model: an operation in flight is just "cycles left" and a pending product.
    int          m_left = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_prod = '0;
    logic [15:0] m_pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_prod = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_prod = m_pend;
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pend = signed_mul(multiplicand, multiplier);
                m_left = calc_cycles(multiplier);
                m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("product", 32'(product), 32'(m_prod));
    end

    // Called at a negedge; start is accepted at the next posedge.
    task automatic start_op(input logic [7:0] mc, input logic [7:0] mp);
        multiplicand = mc;
        multiplier   = mp;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) break;
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    int          bc;
    logic [7:0]  ra;
    logic [7:0]  rb;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Model self-pins.
        chk("model_3x5", 32'(signed_mul(8'h03, 8'h05)), 32'h000F);
        chk("model_m128sq", 32'(signed_mul(8'h80, 8'h80)), 32'h4000);

        start_op(8'h03, 8'h05);
        wait_done(bc);
        chk("p_3x5", 32'(product), 32'h000F);
`ifdef BOOTH_EARLY_DONE_EN
        chk("busy_3x5", 32'(bc), 32'd5);
`else
        chk("busy_3x5", 32'(bc), 32'd8);
`endif
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);

        start_op(8'h80, 8'h80);
        wait_done(bc);
        chk("p_m128_m128", 32'(product), 32'h4000);
        @(negedge clk);
        start_op(8'h7F, 8'h80);
        wait_done(bc);
        chk("p_127_m128", 32'(product), 32'hC080);
        @(negedge clk);
        start_op(8'h80, 8'h7F);
        wait_done(bc);
        chk("p_m128_127", 32'(product), 32'hC080);
        @(negedge clk);

        // Back-to-back: start held during the DONE cycle.
        start_op(8'hF9, 8'h06);
        wait_done(bc);
        chk("p_m7x6", 32'(product), 32'hFFD6);
        start_op(8'h02, 8'hFF);
        wait_done(bc);
        chk("p_2xm1_chain", 32'(product), 32'hFFFE);
`ifdef BOOTH_EARLY_DONE_EN
        chk("busy_chain", 32'(bc), 32'd2);
`else
        chk("busy_chain", 32'(bc), 32'd8);
`endif
        @(negedge clk);

        // start re-pulsed during CALC is ignored.
        start_op(8'h0B, 8'h0D);
        @(negedge clk);
        multiplicand = 8'h55;
        multiplier   = 8'h33;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        wait_done(bc);
        chk("p_ignore_restart", 32'(product), 32'h008F);
        @(negedge clk);

        // Asynchronous reset mid-CALC.
        start_op(8'h35, 8'h6B);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_op(8'h04, 8'h04);
        wait_done(bc);
        chk("p_4x4", 32'(product), 32'h0010);
        @(negedge clk);

        start_op(8'h25, 8'h00);
        wait_done(bc);
        chk("p_25x0", 32'(product), 32'h0000);
`ifdef BOOTH_EARLY_DONE_EN
        chk("busy_25x0", 32'(bc), 32'd1);
`else
        chk("busy_25x0", 32'(bc), 32'd8);
`endif
        @(negedge clk);
        start_op(8'h05, 8'hFF);
        wait_done(bc);
        chk("p_5xm1", 32'(product), 32'hFFFB);
`ifdef BOOTH_EARLY_DONE_EN
        chk("busy_5xm1", 32'(bc), 32'd2);
`else
        chk("busy_5xm1", 32'(bc), 32'd8);
`endif
        @(negedge clk);

        // Random operands, random gaps and back-to-back chaining.
        for (int n = 0; n < 300; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n % 16 == 0) ra = 8'h80;
            if (n % 16 == 1) rb = 8'h80;
            if (n % 16 == 2) rb = 8'hFF;
            if (n % 16 == 3) rb = 8'h00;
            start_op(ra, rb);
            wait_done(bc);
            chk("p_random", 32'(product), 32'(signed_mul(ra, rb)));
            chk("busy_random", 32'(bc), 32'(calc_cycles(rb)));
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
